// File: rtl/mem_cache_if.sv
// CPU-side and physical-memory-side signals of the direct-mapped cache.
// The slave modport is the cache; the master modport is its environment.
interface mem_cache_if;
   logic [15:0]  mem_address;
   logic         mem_read;
   logic         mem_write;
   logic [1:0]   mem_byte_enable;
   logic [15:0]  mem_wdata;
   logic [15:0]  mem_rdata;
   logic         mem_resp;
   logic [15:0]  pmem_address;
   logic         pmem_read;
   logic         pmem_write;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;

   modport slave (
      input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
      output mem_rdata, mem_resp,
      output pmem_address, pmem_read, pmem_write, pmem_wdata,
      input  pmem_rdata, pmem_resp
   );

   modport master (
      output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
      input  mem_rdata, mem_resp,
      input  pmem_address, pmem_read, pmem_write, pmem_wdata,
      output pmem_rdata, pmem_resp
   );
endinterface

// File: rtl/mem_cache.sv
// Direct-mapped, write-back, write-allocate cache: 8 lines x 128 bits, 16-bit CPU words.
// state     | meaning
// IDLE      | serve hits combinationally; a miss latches tag/set and leaves
// WRITEBACK | push dirty victim line to pmem until pmem_resp
// ALLOCATE  | fill line from pmem until pmem_resp, then back to IDLE
module mem_cache (
   input  logic       clk,
   input  logic       rst_n,
   mem_cache_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

   state_t       state, state_nxt;
   logic [7:0]   valid, dirty;
   logic [8:0]   tag_arr  [8];
   logic [127:0] data_arr [8];
   logic [8:0]   lat_tag;
   logic [2:0]   lat_set;
   logic [8:0]   req_tag;
   logic [2:0]   req_set;
   logic [6:0]   word_ofs;
   logic         req, hit, miss_start, fill_done;

   assign req_tag    = bus.mem_address[15:7];
   assign req_set    = bus.mem_address[6:4];
   assign word_ofs   = {bus.mem_address[3:1], 4'b0000};
   assign req        = bus.mem_read | bus.mem_write;
   assign hit        = req & valid[req_set] & (tag_arr[req_set] == req_tag);
   assign miss_start = (state == IDLE) & req & ~hit;
   assign fill_done  = (state == ALLOCATE) & bus.pmem_resp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:      if (req && !hit)
                       state_nxt = (valid[req_set] && dirty[req_set]) ? WRITEBACK : ALLOCATE;
         WRITEBACK: if (bus.pmem_resp) state_nxt = ALLOCATE;
         ALLOCATE:  if (bus.pmem_resp) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // pmem side uses the latched tag/set so it stays stable even if the CPU drops its request
   always_comb begin
      bus.mem_resp     = 1'b0;
      bus.pmem_read    = 1'b0;
      bus.pmem_write   = 1'b0;
      bus.pmem_address = 16'h0000;
      bus.mem_rdata    = data_arr[req_set][word_ofs +: 16];
      bus.pmem_wdata   = data_arr[lat_set];
      unique case (state)
         IDLE:      bus.mem_resp = hit;
         WRITEBACK: begin
            bus.pmem_write   = 1'b1;
            bus.pmem_address = {tag_arr[lat_set], lat_set, 4'b0000};
         end
         ALLOCATE:  begin
            bus.pmem_read    = 1'b1;
            bus.pmem_address = {lat_tag, lat_set, 4'b0000};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid   <= '0;
         dirty   <= '0;
         lat_tag <= '0;
         lat_set <= '0;
      end else begin
         if (miss_start) begin
            lat_tag <= req_tag;
            lat_set <= req_set;
         end
         if (state == IDLE && hit && bus.mem_write && bus.mem_byte_enable != 2'b00)
            dirty[req_set] <= 1'b1;
         if (state == WRITEBACK && bus.pmem_resp)
            dirty[lat_set] <= 1'b0;
         if (fill_done) begin
            valid[lat_set] <= 1'b1;
            dirty[lat_set] <= 1'b0;
         end
      end
   end

   // Tag and data storage carry no reset; valid bits guard their contents.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         tag_arr[lat_set]  <= lat_tag;
         data_arr[lat_set] <= bus.pmem_rdata;
      end else if (state == IDLE && hit && bus.mem_write) begin
         if (bus.mem_byte_enable[0])
            data_arr[req_set][word_ofs +: 8] <= bus.mem_wdata[7:0];
         if (bus.mem_byte_enable[1])
            data_arr[req_set][(word_ofs + 7'd8) +: 8] <= bus.mem_wdata[15:8];
      end
   end
endmodule

// File: tb/tb_mem_cache.sv
// Randomized bench for mem_cache against a line-level cache model and a backing-memory array.
module tb_mem_cache;
   logic clk;
   logic rst_n;
   mem_cache_if bus();

   mem_cache dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [127:0] bmem [logic [11:0]];
   logic [7:0]   mvalid, mdirty;
   logic [8:0]   mtag  [8];
   logic [127:0] mdata [8];

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic ensure_line(input logic [11:0] line);
      if (!bmem.exists(line)) bmem[line] = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // One CPU access; the bench plays physical memory with the given response delays.
   task automatic access(input logic [15:0] a, input bit rd, input bit wr,
                         input logic [1:0] be, input logic [15:0] wd, input bit drop,
                         input int dw, input int dr, output logic [15:0] rdata);
      logic [8:0]   t;
      logic [2:0]   s, w;
      logic [127:0] line;
      logic [15:0]  exp_rd;
      bit           hit, exp_wb, fill_seen, dropped;
      int           cyc, wcnt, rcnt, resp_cnt, tail, lat, exp_lat;
      t = a[15:7]; s = a[6:4]; w = a[3:1];
      ensure_line(a[15:4]);
      hit     = mvalid[s] && (mtag[s] == t);
      exp_wb  = !hit && mvalid[s] && mdirty[s];
      line    = hit ? mdata[s] : bmem[a[15:4]];
      exp_rd  = line[w*16 +: 16];
      exp_lat = hit ? 0 : 1 + (exp_wb ? dw : 0) + dr;
      cyc = 0; wcnt = 0; rcnt = 0; resp_cnt = 0; tail = 0; lat = -1;
      fill_seen = 0; dropped = 0; rdata = 16'h0;
      while (cyc < 100 && lat < 0 && !(fill_seen && dropped && tail >= 2)) begin
         @(negedge clk);
         if (cyc == 0) begin
            bus.mem_address = a; bus.mem_read = rd; bus.mem_write = wr;
            bus.mem_byte_enable = be; bus.mem_wdata = wd;
         end
         bus.pmem_resp  = (cyc == 0) && ($urandom_range(0, 3) == 0);
         bus.pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
         if (bus.pmem_write) begin
            wcnt++;
            chk("wb_addr", bus.pmem_address, {mtag[s], s, 4'b0000});
            chk("wb_data", bus.pmem_wdata, mdata[s]);
            chk("wb_no_read", bus.pmem_read, 1'b0);
            if (wcnt == dw) bus.pmem_resp = 1'b1;
         end else if (bus.pmem_read) begin
            rcnt++;
            chk("fill_addr", bus.pmem_address, {t, s, 4'b0000});
            bus.pmem_rdata = bmem[a[15:4]];
            if (rcnt == dr) begin
               bus.pmem_resp = 1'b1;
               fill_seen = 1;
            end
         end
         if (drop && (bus.pmem_read || bus.pmem_write)) begin
            bus.mem_read = 1'b0; bus.mem_write = 1'b0; dropped = 1;
         end
         #1;
         if (bus.mem_resp) begin
            resp_cnt++;
            lat = cyc;
            rdata = bus.mem_rdata;
         end
         if (fill_seen && dropped) tail++;
         cyc++;
      end
      @(negedge clk);
      bus.pmem_resp = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      if (dropped) begin
         chk("drop_no_resp", resp_cnt, 0);
         chk("drop_fill_done", fill_seen, 1'b1);
      end else begin
         chk("resp_seen", lat >= 0, 1'b1);
         chk("latency", lat, exp_lat);
         if (!wr) chk("rdata", rdata, exp_rd);
      end
      chk("wb_cycles", wcnt, exp_wb ? dw : 0);
      chk("fill_cycles", rcnt, hit ? 0 : dr);
      if (!hit) begin
         if (exp_wb) bmem[{mtag[s], s}] = mdata[s];
         mtag[s] = t; mdata[s] = bmem[a[15:4]]; mvalid[s] = 1'b1; mdirty[s] = 1'b0;
      end
      if (!dropped && wr) begin
         if (be[0]) mdata[s][w*16 +: 8]     = wd[7:0];
         if (be[1]) mdata[s][w*16 + 8 +: 8] = wd[15:8];
         if (be != 2'b00) mdirty[s] = 1'b1;
      end
   endtask

   logic [15:0] r;
   logic [15:0] ra;
   int          op;
   bit          seen;

   initial begin
      rst_n = 1'b0;
      bus.mem_address = '0; bus.mem_read = 0; bus.mem_write = 0;
      bus.mem_byte_enable = '0; bus.mem_wdata = '0;
      bus.pmem_rdata = '0; bus.pmem_resp = 0;
      mvalid = '0; mdirty = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_pmem_read", bus.pmem_read, 1'b0);
      chk("rst_pmem_write", bus.pmem_write, 1'b0);
      chk("rst_mem_resp", bus.mem_resp, 1'b0);
      @(negedge clk) rst_n = 1'b1;

      // Cold read, hit, byte write, dirty eviction, clean conflict
      bmem[12'h001] = 128'h0123_4567_89AB_CDEF_0011_2233_CAFE_BEEF;
      access(16'h0012, 1, 0, 2'b00, 16'h0, 0, 1, 3, r);
      chk("cold_word1", r, 16'hCAFE);
      access(16'h0012, 1, 0, 2'b00, 16'h0, 0, 1, 1, r);
      chk("warm_word1", r, 16'hCAFE);
      access(16'h0012, 0, 1, 2'b01, 16'hAB34, 0, 1, 1, r);
      access(16'h0012, 1, 0, 2'b00, 16'h0, 0, 1, 1, r);
      chk("byte_wr_readback", r, 16'hCA34);
      access(16'h0092, 1, 0, 2'b00, 16'h0, 0, 2, 2, r);
      chk("evicted_line", bmem[12'h001][31:16], 16'hCA34);
      access(16'h0112, 1, 0, 2'b00, 16'h0, 0, 2, 2, r);

      // Request dropped during allocate, then the line is resident
      access(16'h0346, 1, 0, 2'b00, 16'h0, 1, 1, 3, r);
      access(16'h0346, 1, 0, 2'b00, 16'h0, 0, 1, 1, r);

      // Reset during allocate; a late pmem_resp must be ignored
      ensure_line(12'h023);
      @(negedge clk);
      bus.mem_address = 16'h0234; bus.mem_read = 1'b1;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk); #1;
         seen = bus.pmem_read;
      end
      chk("rst_fill_started", seen, 1'b1);
      @(negedge clk);
      rst_n = 1'b0; bus.mem_read = 1'b0;
      #1;
      chk("rst_drops_pmem_read", bus.pmem_read, 1'b0);
      chk("rst_mem_resp_low", bus.mem_resp, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      bus.pmem_resp = 1'b1;
      bus.pmem_rdata = 128'h0;
      @(negedge clk) bus.pmem_resp = 1'b0;
      mvalid = '0; mdirty = '0;
      access(16'h0234, 1, 0, 2'b00, 16'h0, 0, 1, 2, r);

      // Random traffic over a small tag range to force conflicts and evictions
      for (int i = 0; i < 250; i++) begin
         ra = {9'($urandom_range(0, 2)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
         op = $urandom_range(0, 3);
         access(ra, op != 2, op >= 2, 2'($urandom_range(0, 3)), 16'($urandom),
                $urandom_range(0, 11) == 0, $urandom_range(1, 4), $urandom_range(1, 4), r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
